// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS main control unit.
//   - 4-bit FSM state encodings
//   - opcode constants
//   - encodings for alu_op, alu_src_b, pc_src, reg_dst and mem_to_reg
//   - op_legal(): whether an opcode is decoded by this control unit
// Configuration: MC_CTRL_JAL_EN adds the JAL state and makes opcode 0x03 legal.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_MADR = 4'd3,
    S_MRD  = 4'd4,
    S_MWB  = 4'd5,
    S_MWR  = 4'd6,
    S_REX  = 4'd7,
    S_RWB  = 4'd8,
    S_BEQ  = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11,
    S_JMP  = 4'd12
`ifdef MC_CTRL_JAL_EN
    , S_JAL = 4'd13
`endif
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // ALU B operand select
  localparam logic [2:0] SRCB_B       = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIMM    = 3'b010;
  localparam logic [2:0] SRCB_SIMM_S2 = 3'b011;
  localparam logic [2:0] SRCB_ZIMM    = 3'b100;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Register file write address select
  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  // Register file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: ok = 1'b1;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational output decoder for the multi-cycle control FSM.
// Maps the current state (plus op, zero and mem_ready where they matter) to
// every datapath control signal. Outputs not driven by a state are 0.
// Ports:
//   state_i      current FSM state
//   op_i         IR opcode field
//   zero_i       ALU zero flag (conditional PC write in BEQ)
//   mem_ready_i  memory completes its access this cycle (gates fetch writes)
//   *_o          datapath controls, see mc_ctrl for meaning
// Configuration: MC_CTRL_JAL_EN adds the JAL state outputs.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_wr_o,
  output logic        ir_wr_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        iord_o,
  output logic        reg_wr_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [2:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        illegal_o
);

  logic pc_write;
  logic pc_write_cond;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_wr_o       = 1'b0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = 1'b0;
    iord_o        = 1'b0;
    reg_wr_o      = 1'b0;
    reg_dst_o     = RDST_RT;
    mem_to_reg_o  = M2R_ALUOUT;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRCB_B;
    alu_op_o      = ALU_ADD;
    pc_src_o      = PCSRC_ALU;
    illegal_o     = 1'b0;
    case (state_i)
      S_IF: begin
        // PC+4 and IR load only on the completing cycle, so a wait-stated
        // fetch still increments the PC exactly once.
        mem_rd_o    = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        pc_write    = mem_ready_i;
        ir_wr_o     = mem_ready_i;
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b_o = SRCB_SIMM_S2;
        illegal_o   = ~op_legal(op_i);
      end
      S_MADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_SIMM;
      end
      S_MRD: begin
        mem_rd_o = 1'b1;
        iord_o   = 1'b1;
      end
      S_MWB: begin
        reg_wr_o     = 1'b1;
        mem_to_reg_o = M2R_MDR;
      end
      S_MWR: begin
        mem_wr_o = 1'b1;
        iord_o   = 1'b1;
      end
      S_REX: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_wr_o  = 1'b1;
        reg_dst_o = RDST_RD;
      end
      S_BEQ: begin
        alu_src_a_o   = 1'b1;
        alu_op_o      = ALU_SUB;
        pc_src_o      = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_IEX: begin
        alu_src_a_o = 1'b1;
        if (op_i == OP_ORI) begin
          alu_src_b_o = SRCB_ZIMM;
          alu_op_o    = ALU_OR;
        end else begin
          alu_src_b_o = SRCB_SIMM;
          alu_op_o    = ALU_ADD;
        end
      end
      S_IWB: begin
        reg_wr_o = 1'b1;
      end
      S_JMP: begin
        pc_write = 1'b1;
        pc_src_o = PCSRC_JUMP;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        // PC already holds PC+4: $31 gets the return address on the same
        // edge that the PC takes the jump target.
        pc_write     = 1'b1;
        pc_src_o     = PCSRC_JUMP;
        reg_wr_o     = 1'b1;
        reg_dst_o    = RDST_RA;
        mem_to_reg_o = M2R_PC;
      end
`endif
      default: ;
    endcase
  end

  assign pc_wr_o = pc_write | (pc_write_cond & zero_i);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore main control FSM for the multi-cycle MIPS CPU.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback; memory states wait on mem_ready for wait-stated memory.
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   op, zero, mem_ready            opcode, ALU zero flag, memory handshake
//   pc_wr, ir_wr                   PC / IR enables
//   mem_rd, mem_wr, iord           memory request and address select
//   reg_wr, reg_dst, mem_to_reg    register file write controls
//   alu_src_a, alu_src_b, alu_op   ALU operand/operation selects
//   pc_src                         next-PC select
//   illegal                        one-cycle pulse on an unknown opcode
//   state                          current state (debug)
// Configuration: define MC_CTRL_JAL_EN to decode opcode 0x03 as jal.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_wr,
  output logic        ir_wr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        iord,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic [3:0]  state
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RST;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_IF;
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID: begin
        case (op)
          OP_RTYPE:      state_d = S_REX;
          OP_LW, OP_SW:  state_d = S_MADR;
          OP_BEQ:        state_d = S_BEQ;
          OP_ADDI, OP_ORI: state_d = S_IEX;
          OP_J:          state_d = S_JMP;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:        state_d = S_JAL;
`endif
          default:       state_d = S_IF;
        endcase
      end
      S_MADR: state_d = (op == OP_LW) ? S_MRD : S_MWR;
      S_MRD:  if (mem_ready) state_d = S_MWB;
      S_MWB:  state_d = S_IF;
      S_MWR:  if (mem_ready) state_d = S_IF;
      S_REX:  state_d = S_RWB;
      S_RWB:  state_d = S_IF;
      S_BEQ:  state_d = S_IF;
      S_IEX:  state_d = S_IWB;
      S_IWB:  state_d = S_IF;
      S_JMP:  state_d = S_IF;
`ifdef MC_CTRL_JAL_EN
      S_JAL:  state_d = S_IF;
`endif
      default: state_d = S_RST;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state_i      (state_q),
    .op_i         (op),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .pc_wr_o      (pc_wr),
    .ir_wr_o      (ir_wr),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .iord_o       (iord),
    .reg_wr_o     (reg_wr),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_src_o     (pc_src),
    .illegal_o    (illegal)
  );

  assign state = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main control unit for the MIPS multi-cycle CPU. A Moore FSM sequences one instruction through fetch, decode, execute, memory and writeback. It drives the enables of the datapath's enable flops (PC, IR) and the mux, ALU and memory controls. Memory accesses use a ready handshake so the FSM tolerates wait-stated memory.

## Interface

Parameters: none.

- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode field from IR; stable from the cycle after fetch completes
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_wr`  out  1  PC enable; equals PCWrite OR (PCWriteCond AND `zero`)
- `ir_wr`  out  1  IR enable
- `mem_rd`, `mem_wr`  out  1  memory read / write request
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `reg_wr`  out  1  register file write enable
- `reg_dst`  out  2  write register: 00 = rt, 01 = rd, 10 = $31
- `mem_to_reg`  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  3  000 = B, 001 = 4, 010 = sign-extended imm, 011 = sign-extended imm<<2, 100 = zero-extended imm
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct, 11 = or
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegal`  out  1  one-cycle pulse on an unknown opcode
- `state`  out  4  current state, for debug

## Operation

- States: RST, IF, ID, MADR, MRD, MWB, MWR, REX, RWB, BEQ, IEX, IWB, JMP, JAL.
- Outputs are a pure function of state, plus `mem_ready` / `zero` where noted. Unlisted outputs are 0.
- RST: all outputs 0. Next state is IF.
- IF: `mem_rd`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=001, `alu_op`=00, `pc_src`=00.
  - `ir_wr` = `pc_wr` = `mem_ready`.
  - Stay in IF until `mem_ready`, then go to ID.
- ID: `alu_src_a`=0, `alu_src_b`=011, `alu_op`=00 (branch target into ALUOut). Next state by `op`:
  - 0x00 → REX
  - 0x23 / 0x2B → MADR
  - 0x04 → BEQ
  - 0x08 / 0x0D → IEX
  - 0x02 → JMP
  - 0x03 → JAL (macro only)
  - any other opcode → IF with `illegal`=1 this cycle
- MADR: `alu_src_a`=1, `alu_src_b`=010, add. Next is MRD for lw, MWR for sw.
- MRD: `mem_rd`=1, `iord`=1. Hold until `mem_ready`, then go to MWB.
- MWB: `reg_wr`=1, `reg_dst`=00, `mem_to_reg`=01. Next is IF.
- MWR: `mem_wr`=1, `iord`=1. Hold until `mem_ready`, then go to IF.
- REX: `alu_src_a`=1, `alu_src_b`=000, `alu_op`=10. Next is RWB.
- RWB: `reg_wr`=1, `reg_dst`=01. Next is IF.
- BEQ: `alu_src_a`=1, `alu_src_b`=000, `alu_op`=01, `pc_src`=01, `pc_wr`=`zero`. Next is IF.
- IEX: `alu_src_a`=1.
  - addi: `alu_src_b`=010, `alu_op`=00.
  - ori: `alu_src_b`=100, `alu_op`=11.
  - Next is IWB.
- IWB: `reg_wr`=1, `reg_dst`=00. Next is IF.
- JMP: `pc_wr`=1, `pc_src`=10. Next is IF.
- JAL: `pc_wr`=1, `pc_src`=10, `reg_wr`=1, `reg_dst`=10, `mem_to_reg`=10. The PC already holds PC+4, so $31 receives the return address on the same edge that PC takes the target. Next is IF.
- Unreachable state encodings go to RST.

## Timing

- Reset: while `rst`=0, state = RST and all outputs are 0. This is asynchronous and takes effect immediately, including mid-instruction.
- First edge after `rst` rises: RST → IF.
- Cycle counts with `mem_ready` tied high:
  - R-type 4, lw 5, sw 4, addi/ori 4
  - beq 3, j 3, jal 3
- Each wait cycle adds one cycle in IF, MRD or MWR. `mem_rd` / `mem_wr` stay asserted throughout the wait.
- `ir_wr` and `pc_wr` in IF assert only in the `mem_ready` cycle, so the PC increments exactly once per fetch.
- `mem_ready` outside IF / MRD / MWR is ignored.

## Configuration

- `MC_CTRL_JAL_EN` defined: opcode 0x03 is decoded to the JAL state.
- Not defined: the JAL state is absent, 0x03 is illegal (`illegal` pulse, return to IF), and `reg_dst` / `mem_to_reg` never output 10.

## Structure

- Package `mc_ctrl_pkg` holds:
  - state encodings (4-bit)
  - opcode constants
  - `alu_op`, `alu_src_b`, `pc_src`, `reg_dst` and `mem_to_reg` encodings
- The state register lives in `mc_ctrl`.
- Sub-module `mc_ctrl_outdec` is purely combinational: it maps state, `op`, `zero` and `mem_ready` to all control outputs.

## Test plan

- Reset: pulse `rst`=0 mid-MRD → `state`=RST and all outputs 0 immediately; one edge after release `state`=IF and `mem_rd`=1.
- lw, `op`=0x23, `mem_ready`=1 → IF, ID, MADR, MRD, MWB over 5 cycles; `reg_wr`=1 with `mem_to_reg`=01 only in MWB.
- sw, `op`=0x2B, with `mem_ready` low for 3 cycles in MWR → `mem_wr`=1 held for 4 cycles and no `reg_wr`; then IF.
- beq, `op`=0x04 → `pc_wr`=1 in BEQ when `zero`=1; `pc_wr`=0 when `zero`=0; 3 cycles either way.
- Fetch with `mem_ready` low for 2 cycles → `ir_wr` / `pc_wr` assert exactly once, on the third IF cycle.
- `op`=0x03 → with `MC_CTRL_JAL_EN`: JAL state with `reg_dst`=10 and `pc_wr`=1. Without it: `illegal`=1 for one cycle, then IF.
